// File: rtl/gpu_burst_pkg.sv
// Shared types and widths for the VRAM pixel burst writer.
// Buffer state encoding is common to the top and the segment buffers.
package gpu_burst_pkg;

  localparam int VRAM_X_W = 10;
  localparam int VRAM_Y_W = 9;
  localparam int PIX_W    = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    PEND  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/gpu_burst_segment_buf.sv
// One VRAM line-segment buffer: key, pixel data, per-pixel enables.
// Load/write/close/ack controls come from the burst writer top.
module gpu_burst_segment_buf
  import gpu_burst_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int SEG_PIXELS = 16,
  parameter int SEG_W      = $clog2(SEG_PIXELS),
  parameter int KEY_W      = VRAM_Y_W + VRAM_X_W - SEG_W
) (
  input  logic                        clk,
  input  logic                        i_nrst,
  input  logic                        i_load,
  input  logic                        i_wr,
  input  logic [KEY_W-1:0]            i_key,
  input  logic [SEG_W-1:0]            i_slot0,
  input  logic [LANES*PIX_W-1:0]      i_pix,
  input  logic [LANES-1:0]            i_lane_en,
  input  logic                        i_close,
  input  logic                        i_ack,
  output logic [1:0]                  o_state,
  output logic [KEY_W-1:0]            o_key,
  output logic [SEG_PIXELS*PIX_W-1:0] o_data,
  output logic [SEG_PIXELS-1:0]       o_en,
  output logic                        o_full
);

  buf_state_t                  state_q, state_d;
  logic [KEY_W-1:0]            key_q, key_d;
  logic [SEG_PIXELS*PIX_W-1:0] data_q, data_d;
  logic [SEG_PIXELS-1:0]       en_q, en_d;
  logic [SEG_W-1:0]            slot;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    data_d  = data_q;
    en_d    = en_q;
    slot    = '0;
    if (i_load) begin
      key_d   = i_key;
      en_d    = '0;
      state_d = FILL;
    end
    if (i_wr) begin
      for (int l = 0; l < LANES; l++) begin
        slot = i_slot0 + SEG_W'(l);
        if (i_lane_en[l]) begin
          data_d[slot*PIX_W +: PIX_W] = i_pix[l*PIX_W +: PIX_W];
          en_d[slot] = 1'b1;
        end
      end
    end
    if (i_close && state_q == FILL) begin
      state_d = PEND;
    end
    // enables are cleared so the next fill starts from an empty mask
    if (i_ack && state_q == PEND) begin
      state_d = EMPTY;
      en_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= EMPTY;
      key_q   <= '0;
      data_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign o_state = state_q;
  assign o_key   = key_q;
  assign o_data  = data_q;
  assign o_en    = en_q;
  assign o_full  = &en_q;

endmodule

// File: rtl/gpu_pixel_burst_writer.sv
// Ping-pong VRAM segment collector emitting one burst per segment.
// Define PIXEL_MASK_CHECK_EN to add background mask-bit checking.
module gpu_pixel_burst_writer
  import gpu_burst_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int SEG_PIXELS = 16,
  parameter int SEG_W      = $clog2(SEG_PIXELS)
) (
  input  logic                          clk,
  input  logic                          i_nrst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [VRAM_X_W-1:0]           i_scrX,
  input  logic [VRAM_Y_W-1:0]           i_scrY,
  input  logic [LANES*PIX_W-1:0]        i_pixels,
  input  logic [LANES-1:0]              i_pixValid,
  input  logic                          GPU_REG_ForcePixel15MaskSet,
`ifdef PIXEL_MASK_CHECK_EN
  input  logic [LANES-1:0]              i_bgMask,
  input  logic                          GPU_REG_CheckMaskBit,
`endif
  input  logic                          i_flush,
  output logic                          o_burstReq,
  output logic [VRAM_Y_W-1:0]           o_burstAdrY,
  output logic [VRAM_X_W-SEG_W-1:0]     o_burstAdrX,
  output logic [SEG_PIXELS*PIX_W-1:0]   o_burstData,
  output logic [SEG_PIXELS-1:0]         o_burstEn,
  input  logic                          i_burstAck,
  output logic                          o_idle
);

  localparam int KEY_W = VRAM_Y_W + VRAM_X_W - SEG_W;

  logic                        act_q, act_d;
  logic                        flush_q, flush_d;
  logic [1:0]                  st_raw [2];
  buf_state_t                  st [2];
  logic [KEY_W-1:0]            key [2];
  logic [SEG_PIXELS*PIX_W-1:0] dat [2];
  logic [SEG_PIXELS-1:0]       en [2];
  logic [1:0]                  full, load, wr, close, ack, pend;
  logic [KEY_W-1:0]            key_in, out_key;
  logic [LANES*PIX_W-1:0]      pix_f;
  logic [LANES-1:0]            lane_en;
  buf_state_t                  act_st, oth_st, tgt_st;
  logic                        mismatch, close_ok, accept;
  logic                        any_en, swap, tgt, new_fill;

  always_comb begin
    pix_f = i_pixels;
    for (int l = 0; l < LANES; l++) begin
      pix_f[l*PIX_W + PIX_W-1] = i_pixels[l*PIX_W + PIX_W-1]
                                 | GPU_REG_ForcePixel15MaskSet;
    end
  end

`ifdef PIXEL_MASK_CHECK_EN
  assign lane_en = i_pixValid
                 & ~(i_bgMask & {LANES{GPU_REG_CheckMaskBit}});
`else
  assign lane_en = i_pixValid;
`endif

  // a swap closes the active buffer and steers the group to the partner
  always_comb begin
    key_in   = {i_scrY, i_scrX[VRAM_X_W-1:SEG_W]};
    act_st   = st[act_q];
    oth_st   = st[!act_q];
    mismatch = (act_st == FILL) && (key[act_q] != key_in);
    close_ok = (act_st == FILL) && (oth_st == EMPTY);
    o_ready  = !((act_st == PEND) || (mismatch && oth_st != EMPTY));
    accept   = i_valid && o_ready;
    any_en   = |lane_en;
    swap     = close_ok
             && (full[act_q] || flush_q || (accept && mismatch));
    tgt      = swap ? !act_q : act_q;
    tgt_st   = swap ? oth_st : act_st;
    load     = '0;
    wr       = '0;
    close    = '0;
    wr[tgt]    = accept;
    load[tgt]  = accept && any_en && (tgt_st == EMPTY);
    close[act_q] = swap;
    ack[0]   = i_burstAck && (st[0] == PEND);
    ack[1]   = i_burstAck && (st[1] == PEND);
    act_d    = tgt;
    new_fill = (tgt_st == FILL) || load[tgt];
    flush_d  = ((flush_q && !swap) || i_flush) && new_fill;
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    gpu_burst_segment_buf #(
      .LANES      (LANES),
      .SEG_PIXELS (SEG_PIXELS),
      .SEG_W      (SEG_W),
      .KEY_W      (KEY_W)
    ) u_buf (
      .clk       (clk),
      .i_nrst    (i_nrst),
      .i_load    (load[g]),
      .i_wr      (wr[g]),
      .i_key     (key_in),
      .i_slot0   (i_scrX[SEG_W-1:0]),
      .i_pix     (pix_f),
      .i_lane_en (lane_en),
      .i_close   (close[g]),
      .i_ack     (ack[g]),
      .o_state   (st_raw[g]),
      .o_key     (key[g]),
      .o_data    (dat[g]),
      .o_en      (en[g]),
      .o_full    (full[g])
    );
    assign st[g] = buf_state_t'(st_raw[g]);
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      act_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      act_q   <= act_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    pend[0]     = (st[0] == PEND);
    pend[1]     = (st[1] == PEND);
    out_key     = '0;
    o_burstData = '0;
    o_burstEn   = '0;
    if (pend[0]) begin
      out_key     = key[0];
      o_burstData = dat[0];
      o_burstEn   = en[0];
    end else if (pend[1]) begin
      out_key     = key[1];
      o_burstData = dat[1];
      o_burstEn   = en[1];
    end
  end

  assign o_burstReq  = |pend;
  assign o_burstAdrY = out_key[KEY_W-1 -: VRAM_Y_W];
  assign o_burstAdrX = out_key[VRAM_X_W-SEG_W-1:0];
  assign o_idle      = (st[0] == EMPTY) && (st[1] == EMPTY) && !flush_q;

endmodule

// File: tb/tb_gpu_pixel_burst_writer.sv
// Directed bench for gpu_pixel_burst_writer, LANES=2, SEG_PIXELS=16.
// Expected values are hand-computed per vector.
module tb_gpu_pixel_burst_writer;

  logic         clk;
  logic         i_nrst;
  logic         i_valid;
  logic         o_ready;
  logic [9:0]   i_scrX;
  logic [8:0]   i_scrY;
  logic [31:0]  i_pixels;
  logic [1:0]   i_pixValid;
  logic         force15;
  logic         i_flush;
  logic         o_burstReq;
  logic [8:0]   o_burstAdrY;
  logic [5:0]   o_burstAdrX;
  logic [255:0] o_burstData;
  logic [15:0]  o_burstEn;
  logic         i_burstAck;
  logic         o_idle;

  int n_vec;
  int n_err;
  logic saw_stall;
  logic [255:0] exp_data;

  gpu_pixel_burst_writer #(
    .LANES      (2),
    .SEG_PIXELS (16)
  ) dut (
    .clk                         (clk),
    .i_nrst                      (i_nrst),
    .i_valid                     (i_valid),
    .o_ready                     (o_ready),
    .i_scrX                      (i_scrX),
    .i_scrY                      (i_scrY),
    .i_pixels                    (i_pixels),
    .i_pixValid                  (i_pixValid),
    .GPU_REG_ForcePixel15MaskSet (force15),
    .i_flush                     (i_flush),
    .o_burstReq                  (o_burstReq),
    .o_burstAdrY                 (o_burstAdrY),
    .o_burstAdrX                 (o_burstAdrX),
    .o_burstData                 (o_burstData),
    .o_burstEn                   (o_burstEn),
    .i_burstAck                  (i_burstAck),
    .o_idle                      (o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [9:0] x, input logic [8:0] y,
                      input logic [15:0] p0, input logic [15:0] p1,
                      input logic [1:0] pv, input logic frc,
                      input logic fl);
    i_valid    = 1'b1;
    i_scrX     = x;
    i_scrY     = y;
    i_pixels   = {p1, p0};
    i_pixValid = pv;
    force15    = frc;
    i_flush    = fl;
    if (!o_ready) saw_stall = 1'b1;
    for (int k = 0; k < 20 && !o_ready; k++) @(negedge clk);
    if (!o_ready) check("ready_wait", {255'b0, o_ready}, 256'd1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    force15 = 1'b0;
  endtask

  task automatic flush_pulse();
    i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    i_burstAck = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_burstAck = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    saw_stall = 1'b0;
    i_nrst = 1'b0;
    i_valid = 1'b0;
    i_scrX = '0;
    i_scrY = '0;
    i_pixels = '0;
    i_pixValid = '0;
    force15 = 1'b0;
    i_flush = 1'b0;
    i_burstAck = 1'b0;
    repeat (2) @(negedge clk);
    i_nrst = 1'b1;
    @(negedge clk);

    check("rst_req", {255'b0, o_burstReq}, 256'd0);
    check("rst_ready", {255'b0, o_ready}, 256'd1);
    check("rst_idle", {255'b0, o_idle}, 256'd1);
    check("rst_data", o_burstData, 256'd0);

    // full segment y=5, slot s holds 0x0100+s
    exp_data = '0;
    for (int k = 0; k < 8; k++) begin
      send(10'(2*k), 9'd5, 16'(16'h0100 + 2*k), 16'(16'h0101 + 2*k),
           2'b11, 1'b0, 1'b0);
    end
    for (int s = 0; s < 16; s++) exp_data[s*16 +: 16] = 16'(16'h0100 + s);
    check("full_latency", {255'b0, o_burstReq}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    check("full_req", {255'b0, o_burstReq}, 256'd1);
    check("full_adry", {247'b0, o_burstAdrY}, 256'd5);
    check("full_adrx", {250'b0, o_burstAdrX}, 256'd0);
    check("full_en", {240'b0, o_burstEn}, 256'hFFFF);
    check("full_data", o_burstData, exp_data);
    check("full_nostall", {255'b0, saw_stall}, 256'd0);
    ack_pulse();
    check("full_idle", {255'b0, o_idle}, 256'd1);

    // key change pushes the first segment out
    send(10'd4, 9'd3, 16'hA004, 16'hA005, 2'b11, 1'b0, 1'b0);
    send(10'd40, 9'd3, 16'h0028, 16'h0029, 2'b11, 1'b0, 1'b0);
    check("mis_req", {255'b0, o_burstReq}, 256'd1);
    check("mis_adry", {247'b0, o_burstAdrY}, 256'd3);
    check("mis_adrx", {250'b0, o_burstAdrX}, 256'd0);
    check("mis_en", {240'b0, o_burstEn}, 256'h0030);
    check("mis_data", {224'b0, o_burstData[95:64]}, 256'hA005A004);

    // third key while a burst is pending stalls until after ack
    i_valid = 1'b1;
    i_scrX = 10'd64;
    i_scrY = 9'd3;
    i_pixels = {16'hC041, 16'hC040};
    i_pixValid = 2'b11;
    #1;
    check("stall_ready0", {255'b0, o_ready}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    check("stall_ready1", {255'b0, o_ready}, 256'd0);
    check("stall_hold", {250'b0, o_burstAdrX}, 256'd0);
    i_burstAck = 1'b1;
    #1;
    check("stall_ready_ack", {255'b0, o_ready}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    i_burstAck = 1'b0;
    check("stall_ready_post", {255'b0, o_ready}, 256'd1);
    check("stall_req_gap", {255'b0, o_burstReq}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("stall_req", {255'b0, o_burstReq}, 256'd1);
    check("stall_adrx", {250'b0, o_burstAdrX}, 256'd2);
    check("stall_en", {240'b0, o_burstEn}, 256'h0300);
    check("stall_data", {224'b0, o_burstData[159:128]}, 256'h00290028);
    ack_pulse();
    check("open_idle", {255'b0, o_idle}, 256'd0);
    check("open_req", {255'b0, o_burstReq}, 256'd0);
    flush_pulse();
    check("fl_req", {255'b0, o_burstReq}, 256'd1);
    check("fl_adrx", {250'b0, o_burstAdrX}, 256'd4);
    check("fl_en", {240'b0, o_burstEn}, 256'h0003);
    check("fl_data", {224'b0, o_burstData[31:0]}, 256'hC041C040);
    ack_pulse();
    check("fl_idle", {255'b0, o_idle}, 256'd1);

    // bit15 forcing, flush coincident with the group
    send(10'd0, 9'd7, 16'h1234, 16'h0000, 2'b01, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("frc1_req", {255'b0, o_burstReq}, 256'd1);
    check("frc1_data", {240'b0, o_burstData[15:0]}, 256'h9234);
    check("frc1_en", {240'b0, o_burstEn}, 256'h0001);
    ack_pulse();
    send(10'd0, 9'd7, 16'h1234, 16'h0000, 2'b01, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("frc0_data", {240'b0, o_burstData[15:0]}, 256'h1234);
    ack_pulse();

    // partial lane valid, then flush
    send(10'd6, 9'd8, 16'hFFFF, 16'h0777, 2'b10, 1'b0, 1'b0);
    flush_pulse();
    check("part_en", {240'b0, o_burstEn}, 256'h0080);
    check("part_data", {240'b0, o_burstData[127:112]}, 256'h0777);
    check("part_adry", {247'b0, o_burstAdrY}, 256'd8);
    ack_pulse();

    // flush and ack on an idle block do nothing
    flush_pulse();
    repeat (2) @(negedge clk);
    check("idlefl_req", {255'b0, o_burstReq}, 256'd0);
    check("idlefl_idle", {255'b0, o_idle}, 256'd1);
    ack_pulse();
    check("idleack_idle", {255'b0, o_idle}, 256'd1);

    // reset while pending
    send(10'd0, 9'd1, 16'h0011, 16'h0012, 2'b11, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("prerst_req", {255'b0, o_burstReq}, 256'd1);
    i_nrst = 1'b0;
    #1;
    check("rst2_req", {255'b0, o_burstReq}, 256'd0);
    check("rst2_idle", {255'b0, o_idle}, 256'd1);
    check("rst2_ready", {255'b0, o_ready}, 256'd1);
    check("rst2_data", o_burstData, 256'd0);
    check("rst2_en", {240'b0, o_burstEn}, 256'd0);
    @(negedge clk);
    i_nrst = 1'b1;
    @(negedge clk);
    send(10'd0, 9'd2, 16'h0202, 16'h0203, 2'b11, 1'b0, 1'b0);
    check("post_idle", {255'b0, o_idle}, 256'd0);
    check("post_req", {255'b0, o_burstReq}, 256'd0);
    flush_pulse();
    check("post_adry", {247'b0, o_burstAdrY}, 256'd2);
    check("post_en", {240'b0, o_burstEn}, 256'h0003);
    check("post_data", {224'b0, o_burstData[31:0]}, 256'h02030202);
    ack_pulse();
    check("post_done", {255'b0, o_idle}, 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
